i2c_auto_config_seq: RTL and testbench
======================================

// Module: i2c_auto_config_seq
// PURPOSE
//  Power-up I2C configuration sequencer sitting directly upstream of I2C_interfaces.
//  Replays a built-in command table into the I2C write FIFO (laser drivers, NVIO), starts each
//  transaction, drains any readback, then hands the FIFO/start controls back to the JTAG path.
//  Outputs feed I2C_interfaces; JTAG user-register signals pass through when the sequencer is idle.
// PARAMETERS
//  AUTO_START   1        1: run the table once after reset release; 0: run only on SEQ_GO.
//  PWRUP_DLY    16'd4000 CLK40 cycles of wait after reset before the first run (100 us).
//  ROM_DEPTH    32       command table depth (words); address width = clog2(ROM_DEPTH).
//  TIMEOUT_CYC  20'd400000  max cycles from I2C_START to I2C_CLR_START (10 ms); overflow = error.
// PORTS
//  CLK40             in   1  system clock, 40 MHz; all logic on rising edge.
//  RST_N             in   1  asynchronous active-low reset.
//  SEQ_GO            in   1  1-cycle pulse: rerun table; ignored while SEQ_BUSY=1.
//  JTAG_WRT_DATA     in   8  JTAG write-FIFO byte (pass-through).
//  JTAG_WE, JTAG_RDENA, JTAG_RESET, JTAG_START  in 1 each  JTAG strobes (pass-through).
//  JTAG_CLR_START    out  1  I2C_CLR_START forwarded to JTAG; forced 0 while SEQ_BUSY.
//  I2C_WRT_FIFO_DATA out  8  byte to I2C write FIFO.
//  I2C_WE, I2C_RDENA, I2C_RESET, I2C_START  out 1 each  to I2C_interfaces.
//  I2C_CLR_START     in   1  transaction complete from I2C command parser.
//  I2C_WRT_FULL      in   1  write FIFO full.
//  I2C_RBK_EMPTY     in   1  readback FIFO empty.
//  I2C_RBK_DATA      in   8  readback FIFO dout (first-word-fall-through not assumed).
//  SEQ_BUSY          out  1  sequencer owns the I2C controls.
//  SEQ_DONE          out  1  table completed without error (sticky until next run).
//  SEQ_ERR           out  1  timeout occurred (sticky until next run).
//  SEQ_XACT_CNT      out  6  transactions completed this run (saturates at 63).
//  SEQ_RBK_LAST      out  8  last byte drained from the readback FIFO.
// BEHAVIOUR
//  Reset: all outputs 0, state PWRUP (AUTO_START=1) or IDLE (AUTO_START=0), ROM address 0.
//  Table word [9:0]: [9]=END_OF_LIST, [8]=END_OF_XACT, [7:0]=byte (dev-select, n-byte/read, data).
//  Mux: SEQ_BUSY=0 -> I2C_* outputs = JTAG_* inputs combinationally; SEQ_BUSY=1 -> registered FSM
//   values; JTAG strobes dropped (not queued).
//  FSM: IDLE -(SEQ_GO)-> FLUSH; PWRUP -(PWRUP_DLY cycles)-> FLUSH.
//   FLUSH: I2C_RESET=1 for 2 cycles; clear DONE/ERR/XACT_CNT, ROM addr=0 -> LOAD.
//   LOAD: per cycle, if !I2C_WRT_FULL: I2C_WE=1 with ROM byte, addr+1; FULL stalls (no WE, no addr++).
//    Word with [8]=1 pushed last -> GO.
//   GO: I2C_START=1 held until I2C_CLR_START=1 -> START drops same cycle -> DRAIN; XACT_CNT+1.
//    Timeout counter reaches TIMEOUT_CYC -> ERR=1, START=0, I2C_RESET 2 cycles -> IDLE.
//   DRAIN: !I2C_RBK_EMPTY -> RDENA=1 one cycle, capture I2C_RBK_DATA next cycle into SEQ_RBK_LAST,
//    repeat; RBK_EMPTY -> NEXT (no RDENA when empty).
//   NEXT: last word had [9]=1 or addr wrapped past ROM_DEPTH-1 -> DONE=1 -> IDLE; else LOAD.
//  SEQ_BUSY=1 in all states except IDLE. Latency SEQ_GO -> first I2C_WE: 3 cycles.
//  Simultaneous I2C_CLR_START and timeout terminal count: CLR_START wins (no error).
//  Word with [9]=1 and [8]=0: treated as END_OF_XACT too. Empty table (word0=10'h300): one transaction.
//  RST_N low mid-run: immediate abort, all outputs 0; AUTO_START=1 reruns from word 0 after PWRUP_DLY.
// TESTING
//  1 AUTO_START=1, 2-xact table (4+3 bytes), CLR_START 50 cyc after START -> 7 WE pulses,
//    2 START windows, XACT_CNT=2, DONE=1, ERR=0.
//  2 Read xact, model queues 2 rbk bytes 8'h5A,8'hC3 -> 2 RDENA pulses, SEQ_RBK_LAST=8'hC3.
//  3 WRT_FULL high 10 cycles during LOAD -> no WE, no byte lost; byte order at FIFO = table order.
//  4 CLR_START never returns -> ERR=1 at TIMEOUT_CYC, I2C_RESET 2 cycles, DONE=0, SEQ_BUSY=0.
//  5 Idle: JTAG_WE/START/RDENA toggled -> mirrored on I2C_*; during BUSY they are blocked,
//    JTAG_CLR_START=0.
//  6 RST_N low during GO -> all outputs 0 at once; after release run restarts, completes DONE=1.

Source files
------------

// File: rtl/i2c_auto_config_seq.sv
// i2c_auto_config_seq: power-up configuration sequencer sitting in front of I2C_interfaces.
// Replays a built-in command table into the I2C write FIFO, then hands the I2C controls back to JTAG.
module i2c_auto_config_seq #(
  parameter bit          AUTO_START  = 1'b1,
  parameter logic [15:0] PWRUP_DLY   = 16'd4000,
  parameter int          ROM_DEPTH   = 32,
  parameter logic [19:0] TIMEOUT_CYC = 20'd400000,
  // Word i lives at [i*10 +: 10]: [9]=END_OF_LIST, [8]=END_OF_XACT, [7:0]=byte.
  parameter logic [ROM_DEPTH*10-1:0] ROM_TABLE = (ROM_DEPTH*10)'({
    10'h300, 10'h081, 10'h0E8,
    10'h100, 10'h003, 10'h002, 10'h0E8,
    10'h120, 10'h011, 10'h002, 10'h0A0,
    10'h13F, 10'h010, 10'h002, 10'h0A0})
) (
  input  logic       clk40_i,
  input  logic       rst_n_i,
  input  logic       seq_go_i,
  input  logic [7:0] jtag_wrt_data_i,
  input  logic       jtag_we_i,
  input  logic       jtag_rdena_i,
  input  logic       jtag_reset_i,
  input  logic       jtag_start_i,
  output logic       jtag_clr_start_o,
  output logic [7:0] i2c_wrt_fifo_data_o,
  output logic       i2c_we_o,
  output logic       i2c_rdena_o,
  output logic       i2c_reset_o,
  output logic       i2c_start_o,
  input  logic       i2c_clr_start_i,
  input  logic       i2c_wrt_full_i,
  input  logic       i2c_rbk_empty_i,
  input  logic [7:0] i2c_rbk_data_i,
  output logic       seq_busy_o,
  output logic       seq_done_o,
  output logic       seq_err_o,
  output logic [5:0] seq_xact_cnt_o,
  output logic [7:0] seq_rbk_last_o
);

  localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FLUSH, S_LOAD, S_GO, S_DRAIN, S_CAPTURE, S_NEXT, S_ERR_RST
  } state_t;

  state_t        state_q, state_d;
  logic [19:0]   cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          eol_q, eol_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [5:0]    xact_q, xact_d;
  logic [7:0]    rbk_q, rbk_d;

  logic [9:0]    rom_word;
  logic          fsm_we, fsm_rdena, fsm_reset, fsm_start;
  logic          busy;

  assign rom_word = ROM_TABLE[int'(addr_q)*10 +: 10];

  always_ff @(posedge clk40_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= AUTO_START ? S_PWRUP : S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      eol_q   <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      xact_q  <= '0;
      rbk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      eol_q   <= eol_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      err_q   <= err_d;
      xact_q  <= xact_d;
      rbk_q   <= rbk_d;
    end
  end

  // cnt_q is shared: power-up delay, the 2-cycle I2C reset pulse and the START timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    eol_d     = eol_q;
    wrap_d    = wrap_q;
    done_d    = done_q;
    err_d     = err_q;
    xact_d    = xact_q;
    rbk_d     = rbk_q;
    fsm_we    = 1'b0;
    fsm_rdena = 1'b0;
    fsm_reset = 1'b0;
    fsm_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (seq_go_i) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      S_PWRUP: begin
        if (cnt_q + 20'd1 >= {4'd0, PWRUP_DLY}) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_FLUSH: begin
        fsm_reset = 1'b1;
        done_d    = 1'b0;
        err_d     = 1'b0;
        xact_d    = '0;
        addr_d    = '0;
        eol_d     = 1'b0;
        wrap_d    = 1'b0;
        if (cnt_q[0]) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_LOAD: begin
        // The last table slot closes the transaction even without a marker, so a run always ends.
        if (!i2c_wrt_full_i) begin
          fsm_we = 1'b1;
          eol_d  = rom_word[9];
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            wrap_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
          if (rom_word[9] || rom_word[8] || addr_q == LAST_ADDR) begin
            state_d = S_GO;
            cnt_d   = '0;
          end
        end
      end
      S_GO: begin
        if (i2c_clr_start_i) begin
          state_d = S_DRAIN;
          if (xact_q != 6'd63) xact_d = xact_q + 6'd1;
        end else begin
          fsm_start = 1'b1;
          if (cnt_q + 20'd1 >= TIMEOUT_CYC) begin
            state_d = S_ERR_RST;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
      end
      S_ERR_RST: begin
        fsm_reset = 1'b1;
        if (cnt_q[0]) state_d = S_IDLE;
        else          cnt_d   = cnt_q + 20'd1;
      end
      S_DRAIN: begin
        if (!i2c_rbk_empty_i) begin
          fsm_rdena = 1'b1;
          state_d   = S_CAPTURE;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_CAPTURE: begin
        rbk_d   = i2c_rbk_data_i;
        state_d = S_DRAIN;
      end
      S_NEXT: begin
        if (eol_q || wrap_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset forces every output low, including the JTAG pass-through.
  assign busy                = rst_n_i && (state_q != S_IDLE);
  assign seq_busy_o          = busy;
  assign i2c_we_o            = busy ? fsm_we    : (rst_n_i & jtag_we_i);
  assign i2c_rdena_o         = busy ? fsm_rdena : (rst_n_i & jtag_rdena_i);
  assign i2c_reset_o         = busy ? fsm_reset : (rst_n_i & jtag_reset_i);
  assign i2c_start_o         = busy ? fsm_start : (rst_n_i & jtag_start_i);
  assign i2c_wrt_fifo_data_o = busy ? (fsm_we ? rom_word[7:0] : 8'h00)
                                    : (rst_n_i ? jtag_wrt_data_i : 8'h00);
  assign jtag_clr_start_o    = rst_n_i && !busy && i2c_clr_start_i;
  assign seq_done_o          = done_q;
  assign seq_err_o           = err_q;
  assign seq_xact_cnt_o      = xact_q;
  assign seq_rbk_last_o      = rbk_q;

endmodule

// File: tb/tb_i2c_auto_config_seq.sv
// tb_i2c_auto_config_seq: self-checking bench with a behavioural I2C_interfaces responder.
// Expected traffic is derived from the command table by walking its end-of-xact/end-of-list rules.
module tb_i2c_auto_config_seq;

  localparam int          DEPTH   = 16;
  localparam logic [15:0] PDLY    = 16'd20;
  localparam logic [19:0] TMO     = 20'd300;
  localparam int          READ_XACT = 2;
  // Two transactions: a 4-byte write, then a 3-byte read closed by an END_OF_LIST-only word.
  localparam logic [DEPTH*10-1:0] TBL = {90'd0, 10'h24C, 10'h081, 10'h0A1,
                                         10'h122, 10'h011, 10'h002, 10'h0A0};

  logic       clk;
  logic       rstN, seqGo;
  logic [7:0] jtagData;
  logic       jtagWe, jtagRdena, jtagReset, jtagStart;
  logic       i2cClrStart, i2cWrtFull, i2cRbkEmpty;
  logic [7:0] i2cRbkData;
  logic       jtagClrStartOut, i2cWe, i2cRdena, i2cReset, i2cStart;
  logic [7:0] i2cData, rbkLast;
  logic       busy, done, err;
  logic [5:0] xactCnt;

  int nChecks = 0;
  int nFails  = 0;

  // Responder and monitor state shared with the directed sequence.
  logic [7:0] weBytes[$];
  logic [7:0] rbkPlan[$];
  logic [7:0] rbkQ[$];
  logic [7:0] expBytes[$];
  int expXacts, firstLen;
  int weWhileFull, fullCycles, startHigh, startWindows, startAge, startWithClr;
  int resetCycles, rdenaCount, runXacts, clrLeak, fullLeft, respDelay;
  bit fullArm, popPending, prevStart, respNever, clrForce;

  i2c_auto_config_seq #(
    .AUTO_START(1'b1), .PWRUP_DLY(PDLY), .ROM_DEPTH(DEPTH),
    .TIMEOUT_CYC(TMO), .ROM_TABLE(TBL)
  ) dut (
    .clk40_i(clk), .rst_n_i(rstN), .seq_go_i(seqGo),
    .jtag_wrt_data_i(jtagData), .jtag_we_i(jtagWe), .jtag_rdena_i(jtagRdena),
    .jtag_reset_i(jtagReset), .jtag_start_i(jtagStart),
    .jtag_clr_start_o(jtagClrStartOut), .i2c_wrt_fifo_data_o(i2cData),
    .i2c_we_o(i2cWe), .i2c_rdena_o(i2cRdena), .i2c_reset_o(i2cReset), .i2c_start_o(i2cStart),
    .i2c_clr_start_i(i2cClrStart), .i2c_wrt_full_i(i2cWrtFull),
    .i2c_rbk_empty_i(i2cRbkEmpty), .i2c_rbk_data_i(i2cRbkData),
    .seq_busy_o(busy), .seq_done_o(done), .seq_err_o(err),
    .seq_xact_cnt_o(xactCnt), .seq_rbk_last_o(rbkLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: drives inputs just after each rising edge, observes outputs at the falling edge.
  initial begin : i2cModel
    i2cClrStart = 1'b0;
    i2cWrtFull  = 1'b0;
    i2cRbkEmpty = 1'b1;
    i2cRbkData  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (popPending && rbkQ.size() > 0) i2cRbkData = rbkQ.pop_front();
      popPending = 1'b0;
      if (fullArm && weBytes.size() == 2) begin
        fullLeft = 10;
        fullArm  = 1'b0;
      end
      i2cWrtFull = (fullLeft > 0);
      if (fullLeft > 0) fullLeft--;
      i2cClrStart = clrForce || (!respNever && startAge > 0 && startAge >= respDelay);
      i2cRbkEmpty = (rbkQ.size() == 0);
      @(negedge clk);
      if (busy) begin
        if (i2cWe) begin
          weBytes.push_back(i2cData);
          if (i2cWrtFull) weWhileFull++;
        end
        if (i2cWrtFull) fullCycles++;
        if (i2cStart) begin
          startHigh++;
          if (!prevStart) startWindows++;
          startAge++;
          if (i2cClrStart) startWithClr++;
        end else begin
          startAge = 0;
        end
        prevStart = i2cStart;
        if (i2cReset) resetCycles++;
        if (i2cRdena) begin
          rdenaCount++;
          if (rbkQ.size() > 0) popPending = 1'b1;
        end
        if (i2cClrStart) begin
          runXacts++;
          if (runXacts == READ_XACT)
            foreach (rbkPlan[k]) rbkQ.push_back(rbkPlan[k]);
        end
        if (jtagClrStartOut) clrLeak++;
      end else begin
        startAge  = 0;
        prevStart = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle SEQ_GO pulse; returns just after the edge that sampled it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    seqGo = 1'b1;
    @(posedge clk);
    #1;
    seqGo = 1'b0;
  endtask

  task automatic clearStats();
    weBytes.delete();
    rbkQ.delete();
    weWhileFull = 0; fullCycles = 0; startHigh = 0; startWindows = 0; startAge = 0;
    startWithClr = 0; resetCycles = 0; rdenaCount = 0; runXacts = 0; clrLeak = 0;
    fullLeft = 0; popPending = 1'b0; prevStart = 1'b0;
  endtask

  task automatic waitIdle(input int maxCyc);
    int n = 0;
    while (busy && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    #1;
    checkOutput("idle reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic checkBytes(input string tag, input int expCount);
    checkOutput({tag, " byte count"}, weBytes.size(), expCount);
    for (int i = 0; i < expCount && i < weBytes.size(); i++)
      checkOutput($sformatf("%s byte %0d", tag, i), {24'd0, weBytes[i]}, {24'd0, expBytes[i]});
  endtask

  initial begin : directed
    logic [DEPTH*10-1:0] tblVec;
    logic [9:0] w;
    int lat;
    logic [4:0] rnd;
    logic [7:0] rndData;

    rstN = 1'b0; seqGo = 1'b0; jtagData = 8'h00;
    jtagWe = 1'b0; jtagRdena = 1'b0; jtagReset = 1'b0; jtagStart = 1'b0;
    respNever = 1'b0; clrForce = 1'b0; fullArm = 1'b0; respDelay = 50;
    clearStats();

    // Reference: walk the table, a transaction closes on [8] or [9], the list on [9] or the last slot.
    tblVec = TBL;
    expXacts = 0;
    firstLen = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w = tblVec[i*10 +: 10];
      expBytes.push_back(w[7:0]);
      if (w[8] || w[9] || i == DEPTH - 1) begin
        expXacts++;
        if (firstLen == 0) firstLen = expBytes.size();
      end
      if (w[9] || i == DEPTH - 1) break;
    end

    #1;
    checkOutput("reset busy",  {31'd0, busy}, 32'd0);
    checkOutput("reset done",  {31'd0, done}, 32'd0);
    checkOutput("reset err",   {31'd0, err},  32'd0);
    checkOutput("reset we",    {31'd0, i2cWe}, 32'd0);
    checkOutput("reset start", {31'd0, i2cStart}, 32'd0);
    checkOutput("reset xact",  {26'd0, xactCnt}, 32'd0);

    // Run 1: automatic power-up run, CLR_START 50 cycles after START, read xact returns 5A, C3.
    rbkPlan = '{8'h5A, 8'hC3};
    @(negedge clk);
    #2;
    rstN = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(i2cWe && busy) && lat < 200);
    checkOutput("powerup->we latency", lat, int'(PDLY) + 2);
    waitIdle(3000);
    checkBytes("run1", expBytes.size());
    checkOutput("run1 start windows", startWindows, expXacts);
    checkOutput("run1 xact cnt", {26'd0, xactCnt}, expXacts);
    checkOutput("run1 done", {31'd0, done}, 32'd1);
    checkOutput("run1 err",  {31'd0, err},  32'd0);
    checkOutput("run1 rdena pulses", rdenaCount, rbkPlan.size());
    checkOutput("run1 rbk last", {24'd0, rbkLast}, 32'h0000_00C3);
    checkOutput("run1 reset cycles", resetCycles, 2);
    checkOutput("run1 start with clr", startWithClr, 0);

    // Idle: JTAG strobes and data are mirrored straight through.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2;
      rnd = 5'($urandom);
      rndData = 8'($urandom);
      {jtagWe, jtagStart, jtagRdena, jtagReset} = rnd[3:0];
      jtagData = rndData;
      #1;
      checkOutput($sformatf("idle we %0d", i),    {31'd0, i2cWe},    {31'd0, rnd[3]});
      checkOutput($sformatf("idle start %0d", i), {31'd0, i2cStart}, {31'd0, rnd[2]});
      checkOutput($sformatf("idle rdena %0d", i), {31'd0, i2cRdena}, {31'd0, rnd[1]});
      checkOutput($sformatf("idle reset %0d", i), {31'd0, i2cReset}, {31'd0, rnd[0]});
      checkOutput($sformatf("idle data %0d", i),  {24'd0, i2cData},  {24'd0, rndData});
    end
    jtagWe = 1'b0; jtagStart = 1'b0; jtagRdena = 1'b0; jtagReset = 1'b0;
    @(posedge clk);
    #2;
    clrForce = 1'b1;
    @(posedge clk);
    #3;
    checkOutput("idle clr mirror high", {31'd0, jtagClrStartOut}, 32'd1);
    clrForce = 1'b0;
    @(posedge clk);
    #3;
    checkOutput("idle clr mirror low", {31'd0, jtagClrStartOut}, 32'd0);

    // Run 2: JTAG strobes held high, FIFO full for 10 cycles mid-load, spurious SEQ_GO while busy.
    rbkPlan = '{8'($urandom), 8'($urandom)};
    respDelay = int'($urandom_range(5, 60));
    clearStats();
    fullArm = 1'b1;
    jtagWe = 1'b1; jtagStart = 1'b1; jtagRdena = 1'b1;
    applyStimulus();
    lat = 1;
    @(negedge clk);
    while (!i2cWe && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("go->we latency", lat, 3);
    applyStimulus();
    waitIdle(3000);
    jtagWe = 1'b0; jtagStart = 1'b0; jtagRdena = 1'b0;
    checkBytes("run2", expBytes.size());
    checkOutput("run2 we while full", weWhileFull, 0);
    checkOutput("run2 full cycles", fullCycles, 10);
    checkOutput("run2 start windows", startWindows, expXacts);
    checkOutput("run2 reset cycles", resetCycles, 2);
    checkOutput("run2 rdena pulses", rdenaCount, rbkPlan.size());
    checkOutput("run2 rbk last", {24'd0, rbkLast}, {24'd0, rbkPlan[rbkPlan.size()-1]});
    checkOutput("run2 xact cnt", {26'd0, xactCnt}, expXacts);
    checkOutput("run2 done", {31'd0, done}, 32'd1);
    checkOutput("run2 jtag clr leak", clrLeak, 0);

    // Run 3: CLR_START never returns.
    respNever = 1'b1;
    clearStats();
    applyStimulus();
    @(negedge clk);
    waitIdle(int'(TMO) + 200);
    respNever = 1'b0;
    checkOutput("tmo err",  {31'd0, err},  32'd1);
    checkOutput("tmo done", {31'd0, done}, 32'd0);
    checkOutput("tmo start cycles", startHigh, int'(TMO));
    checkOutput("tmo reset cycles", resetCycles, 4);
    checkOutput("tmo we count", weBytes.size(), firstLen);
    checkOutput("tmo xact cnt", {26'd0, xactCnt}, 32'd0);

    // Run 4: reset pulled while START is up, then the auto run completes from word 0.
    respDelay = 40;
    rbkPlan = '{8'h5A, 8'hC3};
    clearStats();
    applyStimulus();
    lat = 0;
    while (!i2cStart && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("run4 start seen", {31'd0, i2cStart}, 32'd1);
    repeat ($urandom_range(2, 20)) @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("abort busy",  {31'd0, busy},     32'd0);
    checkOutput("abort start", {31'd0, i2cStart}, 32'd0);
    checkOutput("abort reset", {31'd0, i2cReset}, 32'd0);
    checkOutput("abort err",   {31'd0, err},      32'd0);
    checkOutput("abort xact",  {26'd0, xactCnt},  32'd0);
    checkOutput("abort rbk",   {24'd0, rbkLast},  32'd0);
    repeat (3) @(negedge clk);
    clearStats();
    #2;
    rstN = 1'b1;
    @(negedge clk);
    waitIdle(3000);
    checkBytes("run4", expBytes.size());
    checkOutput("run4 done", {31'd0, done}, 32'd1);
    checkOutput("run4 err",  {31'd0, err},  32'd0);
    checkOutput("run4 xact cnt", {26'd0, xactCnt}, expXacts);
    checkOutput("run4 rbk last", {24'd0, rbkLast}, 32'h0000_00C3);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
